// File: rtl/display.sv
// Two-digit seven-segment display driver with normal, error, busy and off modes.
// Segment order {g,f,e,d,c,b,a}, active-high; both digits registered with one cycle latency.
module display (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  redlight,
  input  logic [10:0] number,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2
);

  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_ERROR  = 2'b01;
  localparam logic [1:0] MODE_BUSY   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  // Decimal digit to segment pattern; out-of-range codes fall back to blank.
  function automatic logic [6:0] digit_glyph(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  logic [3:0] w_units;
  logic [3:0] w_tens;
  logic [6:0] w_seg1_next;
  logic [6:0] w_seg2_next;
  logic [6:0] r_seg1;
  logic [6:0] r_seg2;

  // Both results are below 10, so narrowing to 4 bits loses nothing.
  assign w_units = 4'(number % 11'd10);
  assign w_tens  = 4'((number / 11'd10) % 11'd10);

  // Next-state glyph selection for both digits.
  always_comb begin
    w_seg1_next = GLYPH_BLANK;
    w_seg2_next = GLYPH_BLANK;
    case (redlight)
      MODE_NORMAL: begin
        if (number >= 11'd100) begin
          w_seg1_next = GLYPH_DASH;
          w_seg2_next = GLYPH_DASH;
        end else if (number < 11'd10) begin
          w_seg1_next = GLYPH_BLANK;
          w_seg2_next = digit_glyph(w_units);
        end else begin
          w_seg1_next = digit_glyph(w_tens);
          w_seg2_next = digit_glyph(w_units);
        end
      end
      MODE_ERROR: begin
        w_seg1_next = GLYPH_E;
        w_seg2_next = digit_glyph(w_units);
      end
      MODE_BUSY: begin
        w_seg1_next = GLYPH_DASH;
        w_seg2_next = GLYPH_DASH;
      end
      MODE_OFF: begin
        w_seg1_next = GLYPH_BLANK;
        w_seg2_next = GLYPH_BLANK;
      end
      default: begin
        w_seg1_next = GLYPH_BLANK;
        w_seg2_next = GLYPH_BLANK;
      end
    endcase
  end

  // Output registers; reset blanks the display ahead of any mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg1 <= GLYPH_BLANK;
      r_seg2 <= GLYPH_BLANK;
    end else begin
      r_seg1 <= w_seg1_next;
      r_seg2 <= w_seg2_next;
    end
  end

  assign seg1 = r_seg1;
  assign seg2 = r_seg2;

endmodule

// File: tb/tb_display.sv
// Self-checking bench for display: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_display;

  logic        clk;
  logic        rst;
  logic [1:0]  redlight;
  logic [10:0] number;
  logic [6:0]  seg1;
  logic [6:0]  seg2;

  int checks;
  int errors;

  logic [6:0] glyph_tab [10];

  display dut (
    .clk      (clk),
    .rst      (rst),
    .redlight (redlight),
    .number   (number),
    .seg1     (seg1),
    .seg2     (seg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected segments from the mode rules, using decimal arithmetic on the value.
  function automatic logic [13:0] model(input int mode, input int n);
    int u;
    int t;
    logic [6:0] e1;
    logic [6:0] e2;
    u = n % 10;
    t = (n / 10) % 10;
    e1 = 7'h00;
    e2 = 7'h00;
    case (mode)
      0: begin
        if (n >= 100) begin
          e1 = 7'h40;
          e2 = 7'h40;
        end else if (n < 10) begin
          e1 = 7'h00;
          e2 = glyph_tab[u];
        end else begin
          e1 = glyph_tab[t];
          e2 = glyph_tab[u];
        end
      end
      1: begin
        e1 = 7'h79;
        e2 = glyph_tab[u];
      end
      2: begin
        e1 = 7'h40;
        e2 = 7'h40;
      end
      default: begin
        e1 = 7'h00;
        e2 = 7'h00;
      end
    endcase
    return {e1, e2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redlight = 2'b00;
    number = 11'd57;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({seg1, seg2} !== 14'h0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h/%h expected 00/00", i, seg1, seg2);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h6D, 7'h07}) begin
      errors++;
      $display("FAIL reset_release: got %h/%h expected 6D/07", seg1, seg2);
    end
  endtask

  task automatic test_error();
    redlight = 2'b01;
    number = 11'd1;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h79, 7'h06}) begin
      errors++;
      $display("FAIL error_1: got %h/%h expected 79/06", seg1, seg2);
    end
    number = 11'd1234;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h79, 7'h66}) begin
      errors++;
      $display("FAIL error_1234: got %h/%h expected 79/66", seg1, seg2);
    end
  endtask

  task automatic test_sweep();
    logic [13:0] exp_v;
    redlight = 2'b00;
    for (int n = 0; n < 100; n++) begin
      number = 11'(n);
      tick();
      exp_v = model(0, n);
      checks++;
      if ({seg1, seg2} !== exp_v) begin
        errors++;
        $display("FAIL sweep n=%0d: got %h/%h expected %h/%h", n, seg1, seg2, exp_v[13:7], exp_v[6:0]);
      end
    end
    number = 11'd7;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h00, 7'h07}) begin
      errors++;
      $display("FAIL normal_7: got %h/%h expected 00/07", seg1, seg2);
    end
    number = 11'd0;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h00, 7'h3F}) begin
      errors++;
      $display("FAIL normal_0: got %h/%h expected 00/3F", seg1, seg2);
    end
  endtask

  task automatic test_overflow();
    redlight = 2'b00;
    number = 11'd99;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h6F, 7'h6F}) begin
      errors++;
      $display("FAIL normal_99: got %h/%h expected 6F/6F", seg1, seg2);
    end
    number = 11'd100;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h40, 7'h40}) begin
      errors++;
      $display("FAIL overflow_100: got %h/%h expected 40/40", seg1, seg2);
    end
    number = 11'd2047;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h40, 7'h40}) begin
      errors++;
      $display("FAIL overflow_2047: got %h/%h expected 40/40", seg1, seg2);
    end
  endtask

  task automatic test_modes();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(0, 2047);
      number = 11'(n);
      redlight = 2'b10;
      tick();
      checks++;
      if ({seg1, seg2} !== {7'h40, 7'h40}) begin
        errors++;
        $display("FAIL busy n=%0d: got %h/%h expected 40/40", n, seg1, seg2);
      end
      redlight = 2'b11;
      tick();
      checks++;
      if ({seg1, seg2} !== 14'h0000) begin
        errors++;
        $display("FAIL off n=%0d: got %h/%h expected 00/00", n, seg1, seg2);
      end
    end
  endtask

  task automatic test_latency();
    redlight = 2'b00;
    number = 11'd12;
    tick();
    number = 11'd34;
    #2;
    checks++;
    if ({seg1, seg2} !== {7'h06, 7'h5B}) begin
      errors++;
      $display("FAIL latency_before: got %h/%h expected 06/5B", seg1, seg2);
    end
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h4F, 7'h66}) begin
      errors++;
      $display("FAIL latency_after: got %h/%h expected 4F/66", seg1, seg2);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({seg1, seg2} !== 14'h0000) begin
      errors++;
      $display("FAIL midrun_reset: got %h/%h expected 00/00", seg1, seg2);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({seg1, seg2} !== {7'h4F, 7'h66}) begin
      errors++;
      $display("FAIL midrun_release: got %h/%h expected 4F/66", seg1, seg2);
    end
  endtask

  task automatic test_random();
    int m;
    int n;
    logic r;
    logic [13:0] exp_v;
    for (int i = 0; i < 300; i++) begin
      m = $urandom_range(0, 3);
      n = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 120) : $urandom_range(0, 2047);
      r = ($urandom_range(0, 15) == 0);
      redlight = 2'(m);
      number = 11'(n);
      rst = r;
      tick();
      exp_v = r ? 14'h0000 : model(m, n);
      checks++;
      if ({seg1, seg2} !== exp_v) begin
        errors++;
        $display("FAIL random mode=%0d n=%0d rst=%0b: got %h/%h expected %h/%h",
                 m, n, r, seg1, seg2, exp_v[13:7], exp_v[6:0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    checks = 0;
    errors = 0;
    rst = 1'b1;
    redlight = 2'b00;
    number = 11'd0;
    #1;
    test_reset();
    test_error();
    test_sweep();
    test_overflow();
    test_modes();
    test_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display.md
DISPLAY -- requirements
Module: display

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous active-high reset
- redlight  input  2  display mode select
- number  input  11  unsigned binary value to show
- seg1  output  7  left (tens) digit segments
- seg2  output  7  right (units) digit segments
REQ-002 Segment bit order SHALL be {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a), active-high (1 = segment lit, common-cathode).
REQ-003 The module SHALL have no parameters.

Function
REQ-004 seg1 and seg2 SHALL be registered and update only on the rising edge of clk.
REQ-005 Latency SHALL be exactly 1 cycle: outputs after edge N reflect redlight and number sampled at edge N.
REQ-006 Glyph table (hex) SHALL be:
- digits 0-9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F
- 'E': 79
- '-': 40
- blank: 00
REQ-007 Define units = number mod 10 and tens = (number / 10) mod 10, both computed over the full 11-bit range.
REQ-008 redlight=00 (normal) SHALL behave as follows:
- number 10..99: seg1 = glyph(tens), seg2 = glyph(units).
- number 0..9: seg1 = blank (leading-zero suppression), seg2 = glyph(units); number=0 shows blank,"0".
- number >= 100: overflow; seg1 = '-', seg2 = '-'.
REQ-009 redlight=01 (error) SHALL set seg1 = 'E' and seg2 = glyph(units), i.e. the error code, for any number.
REQ-010 redlight=10 (busy) SHALL set seg1 = '-' and seg2 = '-', ignoring number.
REQ-011 redlight=11 (off) SHALL set both seg1 and seg2 to blank.
REQ-012 Mode and value changes SHALL take effect on the next edge with no intermediate or glitch states on the outputs.
REQ-013 The module SHALL contain no other state beyond the two output registers.

Reset
REQ-014 When rst=1 at a rising edge, seg1 and seg2 SHALL both become 00 (blank), regardless of redlight and number.
REQ-015 Reset SHALL take priority over all inputs.
REQ-016 On the first edge with rst=0, the outputs SHALL reflect the current inputs per REQ-008..011.
REQ-017 Asserting reset mid-operation SHALL blank both outputs on that edge.
REQ-018 Before the first reset the output values are don't-care; the bench SHALL apply reset first.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- rst=1 for 2 cycles with redlight=00, number=57 -> seg1=00, seg2=00; release -> next edge seg1=6D, seg2=07.
- redlight=01, number=1 -> after 1 edge seg1=79, seg2=06; with number=1234 -> seg1=79, seg2=66.
- redlight=00, sweep number 0..99 -> tens/units glyphs correct; number=7 -> seg1=00, seg2=07; number=0 -> seg1=00, seg2=3F.
- redlight=00, number=99 -> 6F/6F; number=100 -> 40/40; number=2047 -> 40/40.
- redlight=10 -> 40/40; redlight=11 -> 00/00, for any number.
- Latency check: change number 12->34 at edge N -> outputs 3F... correction: 06/5B until edge N, then 4F/66 after edge N; rst asserted mid-run -> 00/00 on that edge.
